downscale_multi: RTL and testbench



---
 rtl/downscale_pkg.sv | 8 +
 rtl/downscale_ch.sv | 67 ++++++
 rtl/downscale_multi.sv | 28 ++
 tb/tb_downscale_multi.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/downscale_pkg.sv
// downscale_pkg: shared edge-mode encodings and default width for the trigger prescaler
package downscale_pkg;
  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;
  localparam int DATA_W_DEF = 16;
endpackage

// File: rtl/downscale_ch.sv
// downscale_ch: one prescaler channel (synchroniser, edge detect, Nth-edge counter); DOWNSCALE_MULTI_FIRST_EN fires on the first edge after reset/clr
module downscale_ch
  import downscale_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic [DATA_W-1:0] down,
  input  logic [1:0]        mode,
  input  logic              clr,
  output logic              dout
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [DATA_W-1:0]      cnt_q;
  logic                   s;
  logic                   rise;
  logic                   fall;
  logic                   edge_det;
  logic                   fire;
  logic                   first;
  assign s = sync_q[SYNC_STAGES-1];
  // synchroniser chain and previous level; never gated by mode or clr so mode changes cannot invent edges
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= s;
    end
  // selected edge and fire decision
  always_comb begin
    rise     = s & ~prev_q;
    fall     = ~s & prev_q;
    edge_det = mode == MODE_RISE ? rise :
               mode == MODE_FALL ? fall :
               mode == MODE_BOTH ? (rise | fall) : 1'b0;
    fire     = edge_det && (down != '0) && (first || cnt_q >= down - DATA_W'(1));
  end
`ifdef DOWNSCALE_MULTI_FIRST_EN
  logic first_q;
  assign first = first_q;
  // phase-align flag: armed by reset/clr, dropped on the first fire
  always_ff @(posedge clk or posedge rst)
    if (rst) first_q <= 1'b1;
    else if (clr) first_q <= 1'b1;
    else if (fire) first_q <= 1'b0;
`else
  assign first = 1'b0;
`endif
  // edge counter and registered pulse; clr beats a coinciding fire
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      dout  <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      dout  <= 1'b0;
    end else begin
      dout  <= fire;
      cnt_q <= fire ? '0 : (edge_det && down != '0) ? cnt_q + DATA_W'(1) : cnt_q;
    end
endmodule

// File: rtl/downscale_multi.sv
// downscale_multi: NCH-channel trigger prescaler top; optional DOWNSCALE_MULTI_FIRST_EN first-edge alignment
module downscale_multi
  import downscale_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        din,
  input  logic [NCH*DATA_W-1:0] down,
  input  logic [2*NCH-1:0]      mode,
  input  logic                  clr,
  output logic [NCH-1:0]        dout
);
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    downscale_ch #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk  (clk),
      .rst  (rst),
      .din  (din[g]),
      .down (down[g*DATA_W +: DATA_W]),
      .mode (mode[2*g +: 2]),
      .clr  (clr),
      .dout (dout[g])
    );
  end
endmodule

// File: tb/tb_downscale_multi.sv
// tb_downscale_multi: directed and random checks of downscale_multi against a sample-history edge-count model
module tb_downscale_multi;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int S   = 2;
`ifdef DOWNSCALE_MULTI_FIRST_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    din;
  logic [NCH*DW-1:0] down;
  logic [2*NCH-1:0]  mode;
  logic              clr;
  logic [NCH-1:0]    dout;
  downscale_multi #(.NCH(NCH), .DATA_W(DW), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .din(din), .down(down), .mode(mode), .clr(clr), .dout(dout)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errs = 0;
  int pc[NCH];
  bit hist[NCH][S+2];
  int cnt_m[NCH];
  bit first_m[NCH];
  logic [NCH-1:0] exp_d = '0;
  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask
  // model: the channel sees the sample taken S edges ago against the one before it
  always begin
    @(posedge clk);
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        for (int j = 0; j < S + 2; j++) hist[i][j] = 1'b0;
        cnt_m[i] = 0;
        first_m[i] = FE;
        exp_d[i] = 1'b0;
      end else begin
        bit sv, pv, e, f;
        int dv;
        int md;
        for (int j = S + 1; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = din[i];
        sv = hist[i][S];
        pv = hist[i][S+1];
        md = int'(mode[2*i +: 2]);
        dv = int'(down[i*DW +: DW]);
        e = (md == 0) ? (sv && !pv) : (md == 1) ? (!sv && pv) : (md == 2) ? (sv != pv) : 1'b0;
        f = e && dv != 0 && (first_m[i] || cnt_m[i] + 1 >= dv);
        if (clr) begin
          cnt_m[i] = 0;
          first_m[i] = FE;
          exp_d[i] = 1'b0;
        end else begin
          exp_d[i] = f;
          if (f) begin
            cnt_m[i] = 0;
            first_m[i] = 1'b0;
          end else if (e && dv != 0) cnt_m[i]++;
        end
      end
    end
    #1;
    checks++;
    if (dout !== exp_d) begin
      errs++;
      $display("FAIL dout @%0t: got %b expected %b", $time, dout, exp_d);
    end
    for (int i = 0; i < NCH; i++) pc[i] += int'(dout[i]);
  end
  task automatic pulses(input logic [NCH-1:0] m, input int n, input int hi, input int lo);
    repeat (n) begin
      din = din | m;
      repeat (hi) @(negedge clk);
      din = din & ~m;
      repeat (lo) @(negedge clk);
    end
  endtask
  task automatic drain();
    repeat (S + 4) @(negedge clk);
  endtask
  task automatic clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask
  int snap[NCH];
  int hold[NCH];
  int n;
  initial begin
    for (int i = 0; i < NCH; i++) pc[i] = 0;
    rst = 1'b1;
    din = '0;
    clr = 1'b0;
    down = '0;
    down[0*DW +: DW] = 3;
    down[1*DW +: DW] = 2;
    down[2*DW +: DW] = 2;
    down[3*DW +: DW] = 0;
    mode = {2'b00, 2'b11, 2'b10, 2'b00};
    @(posedge clk);
    #2;
    chk("reset_dout", int'(dout), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NCH; i++) snap[i] = pc[i];
    pulses(4'hF, 9, 4, 4);
    drain();
    chk("ch0_div3", pc[0] - snap[0], 3);
    chk("ch1_both_div2", pc[1] - snap[1], 9);
    chk("ch2_off", pc[2] - snap[2], 0);
    chk("ch3_down0", pc[3] - snap[3], 0);
    down[3*DW +: DW] = 1;
    snap[3] = pc[3];
    pulses(4'h8, 3, 4, 4);
    drain();
    chk("ch3_down1", pc[3] - snap[3], 3);
    clear();
    down[0*DW +: DW] = 5;
    snap[0] = pc[0];
    pulses(4'h1, 3, 4, 4);
    down[0*DW +: DW] = 2;
    pulses(4'h1, 1, 4, 4);
    drain();
    chk("lower_down", pc[0] - snap[0], FE ? 2 : 1);
    clear();
    snap[0] = pc[0];
    pulses(4'h1, 1, 4, 4);
    din[0] = 1'b1;
    repeat (S) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    din[0] = 1'b0;
    repeat (4) @(negedge clk);
    pulses(4'h1, 2, 4, 4);
    drain();
    chk("clr_vs_fire", pc[0] - snap[0], FE ? 2 : 1);
    clear();
    down[0*DW +: DW] = 4;
    snap[0] = pc[0];
    pulses(4'h1, 9, 2, 2);
    drain();
    chk("div4_9edges", pc[0] - snap[0], FE ? 3 : 2);
    down[0*DW +: DW] = 1;
    din[0] = 1'b1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #2;
      if (dout[0]) begin
        n = k;
        break;
      end
    end
    chk("latency", n, S + 1);
    rst = 1'b1;
    #1;
    chk("async_rst", int'(dout), 0);
    @(negedge clk);
    din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NCH; i++) hold[i] = $urandom_range(1, 5);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (k % 250 == 0) begin
        mode = $urandom;
        for (int i = 0; i < NCH; i++) down[i*DW +: DW] = $urandom_range(0, 4);
      end
      for (int i = 0; i < NCH; i++)
        if (hold[i] == 0) begin
          din[i] = ~din[i];
          hold[i] = $urandom_range(1, 5);
        end else hold[i]--;
      clr = ($urandom_range(0, 49) == 0);
    end
    clr = 1'b0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
